// File: rtl/pcs_tx_ordered_set_ctrl.sv
// Clause 36 PCS transmit sequencer: picks the octet and K/D flag handed to the
// 8b/10b encoder each cycle. It covers idles, config sets, and the packet
// framing /S/ data /V/ /T/ /R/, and keeps every ordered set on an even slot.
module pcs_tx_ordered_set_ctrl #(
  parameter bit EXTRA_R_ALIGN = 1'b1,
  parameter int LINK_TMR_W    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  xmit,
  input  logic [15:0] tx_config_reg,
  input  logic        tx_en,
  input  logic        tx_er,
  input  logic [7:0]  txd,
  input  logic        enc_disparity,
  input  logic        enc_error,
  output logic        enc_enable,
  output logic [7:0]  enc_data,
  output logic        enc_is_control,
  output logic        tx_even,
  output logic        sop_deferred,
  output logic        enc_err_sticky
);

  // This block has no link timers; the width is kept only for interface compatibility.
  if (LINK_TMR_W != 0) begin : g_tmr_reserved
  end

  localparam logic [7:0] K28_5 = 8'hBC, K27_7 = 8'hFB, K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7, K30_7 = 8'hFE;
  localparam logic [7:0] D21_5 = 8'hB5, D2_2  = 8'h42, D5_6  = 8'hC5, D16_2 = 8'h50;

  // The state names the group emitted on the next edge. /T/ is emitted on the
  // exit transition of DATA, so no separate /T/ state is needed.
  typedef enum logic [3:0] {
    IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, SOP, DATA, EOP_R, EOP_R2
  } state_t;

  state_t      state, nstate;
  logic        mode_data, nmode_data;   // latched xmit==DATA, updated only at set boundaries
  logic        c2, nc2;                 // next config set is /C2/
  logic [15:0] cfg_q;
  logic        cfg_ld;
  logic        en_q, er_q;
  logic [7:0]  d_q;
  logic        slot_even;               // parity of the slot being filled on the next edge
  logic [7:0]  g_data;
  logic        g_k, g_sop, bnd;

  // Next group, next state; bnd marks the end of an ordered set, where xmit is resampled.
  always_comb begin
    nstate     = state;
    nmode_data = mode_data;
    nc2        = c2;
    cfg_ld     = 1'b0;
    g_data     = K28_5;
    g_k        = 1'b1;
    g_sop      = 1'b0;
    bnd        = 1'b0;
    case (state)
      IDLE_K: begin
        if (mode_data && en_q) begin
          g_data = K27_7;
          nstate = DATA;
        end else begin
          nstate = IDLE_D;
        end
      end
      IDLE_D: begin
        g_k    = 1'b0;
        g_data = enc_disparity ? D5_6 : D16_2;
        if (mode_data && en_q) nstate = SOP;   // late start: this octet is dropped
        else                   bnd    = 1'b1;
      end
      CFG_K: begin
        cfg_ld = 1'b1;
        nstate = CFG_D;
      end
      CFG_D: begin
        g_k    = 1'b0;
        g_data = c2 ? D2_2 : D21_5;
        nstate = CFG_LO;
      end
      CFG_LO: begin
        g_k    = 1'b0;
        g_data = cfg_q[7:0];
        nstate = CFG_HI;
      end
      CFG_HI: begin
        g_k    = 1'b0;
        g_data = cfg_q[15:8];
        nc2    = ~c2;
        bnd    = 1'b1;
      end
      SOP: begin
        g_data = K27_7;
        g_sop  = 1'b1;
        nstate = DATA;
      end
      DATA: begin
        if (!en_q) begin
          g_data = K29_7;
          nstate = EOP_R;
        end else if (er_q) begin
          g_data = K30_7;
        end else begin
          g_k    = 1'b0;
          g_data = d_q;
        end
      end
      EOP_R: begin
        g_data = K23_7;
        // Carrier extension keeps /R/ going; otherwise pad to an odd last /R/.
        if (!(er_q && !en_q)) begin
          if (slot_even && EXTRA_R_ALIGN) nstate = EOP_R2;
          else                            bnd    = 1'b1;
        end
      end
      EOP_R2: begin
        g_data = K23_7;
        bnd    = 1'b1;
      end
      default: nstate = IDLE_K;
    endcase
    if (bnd) begin
      nstate     = (xmit == 2'b01) ? CFG_K : IDLE_K;
      nmode_data = (xmit == 2'b10);
      if (xmit != 2'b01) nc2 = 1'b0;
    end
  end

  // Input capture, FSM state and registered encoder-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE_K;
      mode_data      <= 1'b0;
      c2             <= 1'b0;
      cfg_q          <= '0;
      en_q           <= 1'b0;
      er_q           <= 1'b0;
      d_q            <= '0;
      slot_even      <= 1'b1;
      enc_enable     <= 1'b0;
      enc_data       <= '0;
      enc_is_control <= 1'b0;
      tx_even        <= 1'b0;
      sop_deferred   <= 1'b0;
      enc_err_sticky <= 1'b0;
    end else begin
      state          <= nstate;
      mode_data      <= nmode_data;
      c2             <= nc2;
      if (cfg_ld) cfg_q <= tx_config_reg;
      en_q           <= tx_en;
      er_q           <= tx_er;
      d_q            <= txd;
      slot_even      <= ~slot_even;
      enc_enable     <= 1'b1;
      enc_data       <= g_data;
      enc_is_control <= g_k;
      tx_even        <= slot_even;
      sop_deferred   <= g_sop;
      enc_err_sticky <= enc_err_sticky | (enc_error & enc_enable);
    end
  end

endmodule
